// File: rtl/jk_pkg.sv
// Shared types and the JK excitation function for jk_excite_driver.
// Build option JK_TOGGLE_EN selects toggle-form excitation (J=K=1 for changing bits).
package jk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_e;

   localparam int ERR_CNT_W = 8;

   // Returns {j,k} that moves a JK flip-flop from q to t on its next clock.
   function automatic logic [1:0] jk_excite(input logic q, input logic t);
      logic [1:0] jk;
`ifdef JK_TOGGLE_EN
      jk = {q ^ t, q ^ t};
`else
      jk = {~q & t, q & ~t};
`endif
      return jk;
   endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation: current Q and target T to J/K drive (combinational).
// Form follows the JK_TOGGLE_EN build option through jk_pkg::jk_excite.
module jk_excite_bit
   import jk_pkg::*;
(
   input  logic q_i,
   input  logic t_i,
   output logic j_o,
   output logic k_o
);

   assign {j_o, k_o} = jk_excite(q_i, t_i);

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a JK flip-flop bank to a target word, verifies Q read-back and retries on mismatch.
// Build option JK_TOGGLE_EN selects toggle-form J/K drive; default is set/reset form.
module jk_excite_driver
   import jk_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_RETRY = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [WIDTH-1:0]     tgt_i,
   input  logic                 tgt_valid_i,
   output logic                 tgt_ready_o,
   output logic [WIDTH-1:0]     j_o,
   output logic [WIDTH-1:0]     k_o,
   input  logic [WIDTH-1:0]     q_in_i,
   output logic                 done_o,
   output logic                 fail_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       tgt_q, tgt_d;
   logic [2:0]             retry_q, retry_d;
   logic [WIDTH-1:0]       j_q, j_d;
   logic [WIDTH-1:0]       k_q, k_d;
   logic                   ready_q, ready_d;
   logic                   done_q, done_d;
   logic                   fail_q, fail_d;
   logic                   err_q, err_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic [WIDTH-1:0]       tgt_sel_s;
   logic [WIDTH-1:0]       exc_j_s;
   logic [WIDTH-1:0]       exc_k_s;

   // In IDLE the word being accepted is not latched yet, so excite from the live input.
   always_comb begin
      if (state_q == IDLE) begin
         tgt_sel_s = tgt_i;
      end else begin
         tgt_sel_s = tgt_q;
      end
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      jk_excite_bit u_bit (
         .q_i (q_in_i[b]),
         .t_i (tgt_sel_s[b]),
         .j_o (exc_j_s[b]),
         .k_o (exc_k_s[b])
      );
   end

   // Next-state and next-output logic; J/K default to hold (0) outside the launch cycle.
   always_comb begin
      state_d   = state_q;
      tgt_d     = tgt_q;
      retry_d   = retry_q;
      j_d       = '0;
      k_d       = '0;
      done_d    = 1'b0;
      fail_d    = 1'b0;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (tgt_valid_i && ready_q) begin
               tgt_d   = tgt_i;
               retry_d = 3'd0;
               j_d     = exc_j_s;
               k_d     = exc_k_s;
               state_d = DRIVE;
            end else begin
               state_d = IDLE;
            end
         end
         DRIVE: begin
            state_d = CHECK;
         end
         CHECK: begin
            if (q_in_i == tgt_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (retry_q < 3'(MAX_RETRY)) begin
               retry_d = retry_q + 3'd1;
               j_d     = exc_j_s;
               k_d     = exc_k_s;
               state_d = DRIVE;
            end else begin
               done_d  = 1'b1;
               fail_d  = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
               if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                  err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
               end else begin
                  err_cnt_d = err_cnt_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   // State and registered outputs; reset abandons any transfer without a DONE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         tgt_q     <= '0;
         retry_q   <= 3'd0;
         j_q       <= '0;
         k_q       <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         tgt_q     <= tgt_d;
         retry_q   <= retry_d;
         j_q       <= j_d;
         k_q       <= k_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign tgt_ready_o = ready_q;
   assign j_o         = j_q;
   assign k_o         = k_q;
   assign done_o      = done_q;
   assign fail_o      = fail_q;
   assign err_o       = err_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench for jk_excite_driver driving a behavioural 4-bit JK flip-flop bank.
// Expected J/K values follow the JK_TOGGLE_EN build option.
module tb_jk_excite_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] tgt = 4'd0;
   logic       tgt_valid = 1'b0;
   logic       tgt_ready;
   logic [3:0] j, k, q_in;
   logic       done, fail, err;
   logic [7:0] err_cnt;

   logic [3:0] bank = 4'b0000;
   logic [3:0] stuck0 = 4'b0000;

   int checks = 0;
   int failures = 0;

   jk_excite_driver #(.WIDTH(4), .MAX_RETRY(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .tgt_i       (tgt),
      .tgt_valid_i (tgt_valid),
      .tgt_ready_o (tgt_ready),
      .j_o         (j),
      .k_o         (k),
      .q_in_i      (q_in),
      .done_o      (done),
      .fail_o      (fail),
      .err_o       (err),
      .err_cnt_o   (err_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural JK bank: Q' = J&~Q | ~K&Q; stuck0 forces read-back bits low.
   always @(posedge clk) bank <= (j & ~bank) | (~k & bank);
   assign q_in = bank & ~stuck0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one word; returns #1 after the accepting edge (E0).
   task automatic send(input logic [3:0] v);
      tgt = v;
      tgt_valid = 1'b1;
      step();
      tgt_valid = 1'b0;
   endtask

   task automatic wait_done(input int max, output int cyc, output int drv, output logic f);
      logic got;
      got = 1'b0;
      cyc = 0;
      f = 1'b0;
      drv = ((j | k) != 4'd0) ? 1 : 0;
      while (!got && cyc < max) begin
         step();
         cyc++;
         if (done) begin
            got = 1'b1;
            f = fail;
         end else if ((j | k) != 4'd0) begin
            drv++;
         end
      end
      if (!got) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, drv, dones;
      logic f;
      logic [3:0] seq [3];
`ifdef JK_TOGGLE_EN
      localparam logic [3:0] T1_J = 4'b1010, T1_K = 4'b1010;
      localparam logic [3:0] T2_J = 4'b1100, T2_K = 4'b1100;
      localparam logic [3:0] T3_J = 4'b0111, T3_K = 4'b0111;
      localparam logic [3:0] T5_J = 4'b1111, T5_K = 4'b1111;
`else
      localparam logic [3:0] T1_J = 4'b1010, T1_K = 4'b0000;
      localparam logic [3:0] T2_J = 4'b0100, T2_K = 4'b1000;
      localparam logic [3:0] T3_J = 4'b0001, T3_K = 4'b0110;
      localparam logic [3:0] T5_J = 4'b1000, T5_K = 4'b0111;
`endif
      seq[0] = 4'b0001;
      seq[1] = 4'b0011;
      seq[2] = 4'b0111;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", tgt_ready, 1);
      check_eq("rst_j", j, 0);
      check_eq("rst_k", k, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_fail", fail, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_errcnt", err_cnt, 0);
      rst = 1'b0;
      step();

      // 0000 -> 1010
      send(4'b1010);
      check_eq("t1_j", j, T1_J);
      check_eq("t1_k", k, T1_K);
      check_eq("t1_ready_low", tgt_ready, 0);
      wait_done(10, cyc, drv, f);
      check_eq("t1_latency", cyc, 2);
      check_eq("t1_fail", f, 0);
      check_eq("t1_ready", tgt_ready, 1);
      check_eq("t1_q", q_in, 4'b1010);
      step();
      check_eq("t1_done_pulse", done, 0);

      // 1010 -> 0110
      send(4'b0110);
      check_eq("t2_j", j, T2_J);
      check_eq("t2_k", k, T2_K);
      wait_done(10, cyc, drv, f);
      check_eq("t2_latency", cyc, 2);
      check_eq("t2_fail", f, 0);
      check_eq("t2_q", q_in, 4'b0110);

      // Bit 0 stuck low: three drives, then DONE+FAIL
      stuck0 = 4'b0001;
      send(4'b0001);
      check_eq("t3_j", j, T3_J);
      check_eq("t3_k", k, T3_K);
      wait_done(20, cyc, drv, f);
      check_eq("t3_latency", cyc, 6);
      check_eq("t3_drives", drv, 3);
      check_eq("t3_fail", f, 1);
      check_eq("t3_err", err, 1);
      check_eq("t3_errcnt", err_cnt, 1);
      step();
      check_eq("t3_fail_pulse", fail, 0);
      stuck0 = 4'b0000;

      // Back-to-back with TGT_VALID held high
      dones = 0;
      tgt = seq[0];
      tgt_valid = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         check_eq("b2b_ready", tgt_ready, (c % 3 == 0) ? 1 : 0);
         check_eq("b2b_done", done, (c % 3 == 0) ? 1 : 0);
         if (done) dones++;
         if (c % 3 == 0) begin
            check_eq("b2b_q", q_in, seq[c / 3 - 1]);
            if (c < 9) tgt = seq[c / 3];
            else tgt_valid = 1'b0;
         end
      end
      check_eq("b2b_dones", dones, 3);

      // Reset during DRIVE
      send(4'b1000);
      check_eq("t5_j", j, T5_J);
      check_eq("t5_k", k, T5_K);
      rst = 1'b1;
      #1;
      check_eq("t5_rst_j", j, 0);
      check_eq("t5_rst_k", k, 0);
      check_eq("t5_rst_ready", tgt_ready, 1);
      step();
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (done) dones++;
      end
      check_eq("t5_no_done", dones, 0);
      check_eq("t5_q_held", q_in, 4'b0111);
      check_eq("t5_errcnt_cleared", err_cnt, 0);
      send(4'b1000);
      wait_done(10, cyc, drv, f);
      check_eq("t5_latency", cyc, 2);
      check_eq("t5_fail", f, 0);
      check_eq("t5_q", q_in, 4'b1000);

      // Forced failures until the error counter saturates
      stuck0 = 4'b0001;
      for (int i = 1; i <= 256; i++) begin
         send(4'b0001);
         wait_done(20, cyc, drv, f);
         if (i == 1 || i == 256) check_eq("sat_fail", f, 1);
         if (i == 100) check_eq("sat_cnt100", err_cnt, 100);
         if (i == 255) check_eq("sat_cnt255", err_cnt, 255);
      end
      check_eq("sat_cnt256", err_cnt, 255);
      check_eq("sat_err", err, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jk_excite_driver.md
# jk_excite_driver

Excitation driver for a bank of gate-level JK flip-flops: accepts a target word over a valid/ready handshake and applies the JK excitation table to Q_IN to compute per-bit J/K drive. It then reads Q back and checks that the bank reached the target, retrying on mismatch. It is the inverse of the JK flip-flop, which maps (J,K,Q) to Q'; this block maps (Q, Q') to (J,K). It sits between sequencing logic (counters, shift-register controllers) and the schematic JK_FlipFlop instances.

## Interface
- WIDTH, 4: number of flip-flops driven (1..16)
- MAX_RETRY, 2: re-drive attempts after the first mismatch (0..7)
- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- TGT  in  WIDTH  target Q word
- TGT_VALID  in  1  TGT is valid
- TGT_READY  out  1  block can accept TGT
- J  out  WIDTH  J inputs to flip-flop bank, registered
- K  out  WIDTH  K inputs to flip-flop bank, registered
- Q_IN  in  WIDTH  Q outputs read back from flip-flop bank
- DONE  out  1  one-cycle pulse, transfer finished
- FAIL  out  1  qualifies DONE: retries exhausted, bank not at target
- ERR  out  1  sticky: any FAIL since reset
- ERR_CNT  out  8  count of FAIL events, saturates at 255

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE: TGT_READY=1, J=K=0.
  - On TGT_VALID & TGT_READY, latch TGT, clear the retry count, and go to DRIVE.
- Excitation per bit, from Q_IN and the latched target T:
  - Q=0,T=0: J=0, K=0
  - Q=0,T=1: J=1, K=0
  - Q=1,T=0: J=0, K=1
  - Q=1,T=1: J=0, K=0
  - Don't-care terms are always driven 0 (default build).
- DRIVE: lasts one cycle; J/K hold the computed values; next state is CHECK.
- CHECK: J=K=0, so the bank holds. Compare Q_IN with the latched target:
  - Match: pulse DONE, FAIL=0, go to IDLE.
  - Mismatch, retry count < MAX_RETRY: increment retry count, recompute J/K from the current Q_IN, go to DRIVE.
  - Mismatch, retries exhausted: pulse DONE with FAIL=1, set ERR, increment ERR_CNT (saturating), go to IDLE.
- TGT_VALID while TGT_READY=0 is ignored. The source must hold TGT until it is accepted.
- RESET (async, any state): go to IDLE, drop the latched target.
  - Reset values: TGT_READY=1, J=0, K=0, DONE=0, FAIL=0, ERR=0, ERR_CNT=0.
  - A transfer in flight is abandoned with no DONE. The bank's Q is not forced.

## Timing
- E0 = the edge that accepts TGT.
  - The J/K values computed from Q_IN sampled at E0 become visible after E0.
  - TGT_READY goes 0 after E0.
- E1: the bank samples J/K; the block enters CHECK and drives J=K=0.
- E2: Q_IN is compared with the target.
  - On success, DONE=1 for the cycle after E2 and TGT_READY=1 in that same cycle.
  - A new TGT may be accepted at E3. Throughput is 1 word per 3 cycles.
- Each retry adds 2 cycles. Worst-case latency to DONE is 2·(MAX_RETRY+1) cycles after E0.
- DONE and FAIL are registered and are never high in consecutive cycles.
- Q_IN must settle within one cycle of the bank clock edge.

## Configuration
- JK_TOGGLE_EN defined: any bit that must change is driven J=1, K=1 (toggle form). Unchanged bits stay J=K=0.
- JK_TOGGLE_EN undefined: set/reset form as tabled above.
- Both forms are valid JK excitation. The resulting Q sequence and timing are identical; only the J/K waveforms differ.

## Structure
- Shared package jk_pkg:
  - state enum (IDLE, DRIVE, CHECK)
  - ERR_CNT_W=8
  - the excitation function jk_excite(q, t) returning {j,k}, with the macro branch inside
- One natural sub-module: jk_excite_bit (combinational, per-bit excitation), instanced WIDTH times. The FSM, counters and registers live in the top level.

## Test plan
- Bank at Q=0000, send TGT=1010 → after E0 J=1010, K=0000; DONE at E2+1, FAIL=0, Q=1010.
- Bank at 1010, send TGT=0110 → J=0100, K=1000 (with JK_TOGGLE_EN: J=K=1100); Q=0110, FAIL=0.
- Force one bank bit stuck at 0, TGT=0001, MAX_RETRY=2 → three DRIVE phases; DONE+FAIL 6 cycles after E0; ERR=1, ERR_CNT=1.
- Back-to-back TGT_VALID held high with 0001, 0011, 0111 → accepts every 3 cycles; TGT_READY low for 2 cycles each; three DONE pulses.
- Assert RESET during DRIVE → J=K=0 and TGT_READY=1 immediately; no DONE; next transfer completes normally.
- 256 forced failures → ERR_CNT saturates at 255, ERR remains 1.
